// File: rtl/sha256_core_pipe.sv
// sha256_core_pipe
//   One 512-bit SHA-256 compression per job. UNROLL chained rounds are applied
//   on every clock, so a block takes N = 64/UNROLL round edges. An opaque tag
//   travels with each job from input to output.
//
// Parameters
//   UNROLL : rounds per clock (1, 2, 4, 8 or 16)
//   TAG_W  : width of the job tag
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : job handshake. in_ready is combinational from out_ready
//   v_in                : chaining value, v_in[31:0] = H0 ... v_in[255:224] = H7
//   data_in             : message block, data_in[7:0] is the first message byte
//   tag_in              : job tag
//   out_valid/out_ready : result handshake
//   hash_out            : result words, byte-swapped back to message byte order
//   tag_out             : tag of the job that produced hash_out
//   busy                : high while rounds are being computed
//   abort               : only with SHA256_CORE_PIPE_ABORT_EN defined; drops the
//                         job in flight or the pending result, back to IDLE
module sha256_core_pipe #(
    parameter int UNROLL = 1,
    parameter int TAG_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SHA256_CORE_PIPE_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [255:0]     v_in,
    input  logic [511:0]     data_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [255:0]     hash_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int         N        = 64 / UNROLL;
    localparam logic [5:0] LAST_CNT = 6'(N - 1);

    localparam logic [31:0] K_TABLE [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

    state_t             state_r;
    logic [5:0]         cnt_r;
    logic [255:0]       v_r;        // chaining value, added back at the end
    logic [255:0]       r_r;        // working variables, a in [31:0] ... h in [255:224]
    logic [511:0]       w_r;        // schedule window, oldest word in [31:0]
    logic [TAG_W-1:0]   tag_r;
    logic [255:0]       step_r_s;
    logic [511:0]       step_w_s;
    logic [511:0]       data_swap_s;
    logic [255:0]       hash_next_s;
    logic               abort_s;
    logic               accept_s;

`ifdef SHA256_CORE_PIPE_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    // UNROLL chained rounds; the window shifts one word per round and the newly
    // generated word enters at the top, so the next round sees it immediately.
    function automatic logic [767:0] run_rounds(input logic [255:0] st,
                                                input logic [511:0] win,
                                                input logic [5:0]   cnt);
        logic [31:0]  a, b, c, d, e, f, g, h, t1, t2, w_new;
        logic [511:0] w;
        logic [5:0]   idx;
        {h, g, f, e, d, c, b, a} = st;
        w = win;
        for (int j = 0; j < UNROLL; j++) begin
            idx   = 6'(int'(cnt) * UNROLL + j);
            t1    = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + K_TABLE[idx] + w[31:0];
            t2    = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
            h     = g;
            g     = f;
            f     = e;
            e     = d + t1;
            d     = c;
            c     = b;
            b     = a;
            a     = t1 + t2;
            w_new = small_sigma1(w[479:448]) + w[319:288] + small_sigma0(w[63:32]) + w[31:0];
            w     = {w_new, w[511:32]};
        end
        return {w, h, g, f, e, d, c, b, a};
    endfunction

    assign {step_w_s, step_r_s} = run_rounds(r_r, w_r, cnt_r);

    assign in_ready = ((state_r == IDLE) || ((state_r == DONE) && out_ready)) && !abort_s;
    assign accept_s = in_valid && in_ready;
    assign busy     = (state_r == ROUND);

    // Message words into big-endian order and the finished hash back out of it.
    always_comb begin
        data_swap_s = 512'd0;
        hash_next_s = 256'd0;
        for (int i = 0; i < 16; i++) begin
            data_swap_s[32*i +: 32] = bswap32(data_in[32*i +: 32]);
        end
        for (int i = 0; i < 8; i++) begin
            hash_next_s[32*i +: 32] = bswap32(v_r[32*i +: 32] + step_r_s[32*i +: 32]);
        end
    end

    // Job FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 6'd0;
            v_r       <= 256'd0;
            r_r       <= 256'd0;
            w_r       <= 512'd0;
            tag_r     <= {TAG_W{1'b0}};
            out_valid <= 1'b0;
            hash_out  <= 256'd0;
            tag_out   <= {TAG_W{1'b0}};
        end else if (abort_s && (state_r != IDLE)) begin
            // Abort wins over completion and over the output handshake.
            state_r   <= IDLE;
            out_valid <= 1'b0;
        end else if (accept_s) begin
            // Covers both IDLE and the same-edge reload from DONE.
            v_r       <= v_in;
            r_r       <= v_in;
            w_r       <= data_swap_s;
            tag_r     <= tag_in;
            cnt_r     <= 6'd0;
            out_valid <= 1'b0;
            state_r   <= ROUND;
        end else begin
            case (state_r)
                IDLE: state_r <= IDLE;
                ROUND: begin
                    r_r   <= step_r_s;
                    w_r   <= step_w_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == LAST_CNT) begin
                        hash_out  <= hash_next_s;
                        tag_out   <= tag_r;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_core_pipe.sv
// Self-checking bench for sha256_core_pipe. Two instances: UNROLL=4 (index 0)
// and UNROLL=1 (index 1), sharing job data inputs but with separate handshakes.
// Results are compared against a plain FIPS 180-4 model with a full 64-word
// message schedule, and against published digests of "abc" and "".
module tb_sha256_core_pipe;

    localparam int TAG_W = 32;
    localparam logic [255:0] IV = 256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667;
    localparam logic [255:0] ABC_DIGEST   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIGEST = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             in_valid_v  [0:1];
    logic             out_ready_v [0:1];
    logic             in_ready_v  [0:1];
    logic             out_valid_v [0:1];
    logic             busy_v      [0:1];
    logic [255:0]     hash_v      [0:1];
    logic [TAG_W-1:0] tag_out_v   [0:1];
`ifdef SHA256_CORE_PIPE_ABORT_EN
    logic             abort_v     [0:1];
`endif
    logic [255:0]     v_in;
    logic [511:0]     data_in;
    logic [TAG_W-1:0] tag_in;

    int errors = 0;
    int checks = 0;

    sha256_core_pipe #(.UNROLL(4), .TAG_W(TAG_W)) u_dut_fast (
        .clk(clk), .rst_n(rst_n),
`ifdef SHA256_CORE_PIPE_ABORT_EN
        .abort(abort_v[0]),
`endif
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .v_in(v_in), .data_in(data_in), .tag_in(tag_in),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .hash_out(hash_v[0]), .tag_out(tag_out_v[0]), .busy(busy_v[0])
    );

    sha256_core_pipe #(.UNROLL(1), .TAG_W(TAG_W)) u_dut_slow (
        .clk(clk), .rst_n(rst_n),
`ifdef SHA256_CORE_PIPE_ABORT_EN
        .abort(abort_v[1]),
`endif
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .v_in(v_in), .data_in(data_in), .tag_in(tag_in),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .hash_out(hash_v[1]), .tag_out(tag_out_v[1]), .busy(busy_v[1])
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression: bytes -> big-endian words, full schedule, 64 rounds,
    // digest emitted byte by byte in message order.
    function automatic logic [255:0] model_hash(input logic [255:0] v, input logic [511:0] d);
        logic [31:0]  W [0:63];
        logic [31:0]  s [0:7];
        logic [31:0]  H [0:7];
        logic [7:0]   msg [0:63];
        logic [31:0]  t1, t2, s0, s1, word;
        logic [255:0] r;
        for (int i = 0; i < 64; i++) msg[i] = d[8*i +: 8];
        for (int t = 0; t < 16; t++) W[t] = {msg[4*t], msg[4*t+1], msg[4*t+2], msg[4*t+3]};
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(W[t-15], 7) ^ rotr(W[t-15], 18) ^ (W[t-15] >> 3);
            s1   = rotr(W[t-2], 17) ^ rotr(W[t-2], 19) ^ (W[t-2] >> 10);
            W[t] = W[t-16] + s0 + W[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) begin
            H[i] = v[32*i +: 32];
            s[i] = H[i];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
                 + ((s[4] & s[5]) ^ (~s[4] & s[6])) + K[t] + W[t];
            t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
                 + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            for (int i = 7; i > 0; i--) s[i] = s[i-1];
            s[4] = s[4] + t1;
            s[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) begin
            word = H[i] + s[i];
            for (int b = 0; b < 4; b++) r[8*(4*i+b) +: 8] = 8'(word >> (24 - 8*b));
        end
        return r;
    endfunction

    // Published digest (first byte in the MSB) into hash_out packing.
    function automatic logic [255:0] to_port(input logic [255:0] digest);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = digest[255-8*k -: 8];
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Called at a negedge with the DUT ready; returns at the negedge after the accept edge.
    task automatic start_job(input int u, input logic [255:0] v, input logic [511:0] d, input logic [31:0] tg);
        v_in = v;
        data_in = d;
        tag_in = tg;
        check("ready_before_accept", 256'(in_ready_v[u]), 256'(1'b1));
        in_valid_v[u] = 1'b1;
        @(negedge clk);
        in_valid_v[u] = 1'b0;
        check("busy_after_accept", 256'(busy_v[u]), 256'(1'b1));
        check("ready_in_round", 256'(in_ready_v[u]), 256'(1'b0));
    endtask

    // Counts edges from the accept edge until out_valid is seen, bounded.
    task automatic wait_result(input int u, output int lat);
        lat = 0;
        while (out_valid_v[u] !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result(input int u);
        out_ready_v[u] = 1'b1;
        @(negedge clk);
        out_ready_v[u] = 1'b0;
        check("valid_drop_after_take", 256'(out_valid_v[u]), 256'(1'b0));
        check("idle_after_take", 256'(busy_v[u]), 256'(1'b0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] abc_blk, empty_blk, d;
        logic [255:0] v, exp_a, exp_b;
        logic [255:0] jv [0:3];
        logic [511:0] jd [0:3];
        logic [31:0]  last_tag_a;
        int lat, hold;

        abc_blk = 512'd0;
        abc_blk[31:0] = 32'h80636261;
        abc_blk[511:504] = 8'h18;
        empty_blk = 512'd0;
        empty_blk[7:0] = 8'h80;

        rst_n = 1'b0;
        v_in = 256'd0;
        data_in = 512'd0;
        tag_in = 32'd0;
        for (int u = 0; u < 2; u++) begin
            in_valid_v[u] = 1'b0;
            out_ready_v[u] = 1'b0;
`ifdef SHA256_CORE_PIPE_ABORT_EN
            abort_v[u] = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset_out_valid", 256'(out_valid_v[u]), 256'(1'b0));
            check("reset_hash", hash_v[u], 256'd0);
            check("reset_tag", 256'(tag_out_v[u]), 256'd0);
            check("reset_busy", 256'(busy_v[u]), 256'(1'b0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) check("ready_after_reset", 256'(in_ready_v[u]), 256'(1'b1));

        // "abc" on the one-round-per-clock core
        start_job(1, IV, abc_blk, 32'hdeadbeef);
        wait_result(1, lat);
        check("abc_u1_latency", 256'(lat), 256'd64);
        check("abc_u1_known", hash_v[1], to_port(ABC_DIGEST));
        check("abc_u1_model", hash_v[1], model_hash(IV, abc_blk));
        check("abc_u1_tag", 256'(tag_out_v[1]), 256'(32'hdeadbeef));
        release_result(1);
        check("hash_held_in_idle", hash_v[1], to_port(ABC_DIGEST));

        // empty message on the four-rounds-per-clock core, then backpressure
        start_job(0, IV, empty_blk, 32'h00000001);
        wait_result(0, lat);
        check("empty_u4_latency", 256'(lat), 256'd16);
        check("empty_u4_known", hash_v[0], to_port(EMPTY_DIGEST));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_valid", 256'(out_valid_v[0]), 256'(1'b1));
            check("bp_hash", hash_v[0], to_port(EMPTY_DIGEST));
            check("bp_tag", 256'(tag_out_v[0]), 256'(32'h00000001));
            check("bp_ready", 256'(in_ready_v[0]), 256'(1'b0));
        end
        v_in = IV;
        data_in = abc_blk;
        tag_in = 32'h00000abc;
        in_valid_v[0] = 1'b1;
        out_ready_v[0] = 1'b1;
        #1;
        check("ready_comb_from_out_ready", 256'(in_ready_v[0]), 256'(1'b1));
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b0;
        check("reload_valid_drop", 256'(out_valid_v[0]), 256'(1'b0));
        check("reload_busy", 256'(busy_v[0]), 256'(1'b1));
        wait_result(0, lat);
        check("reload_latency", 256'(lat), 256'd16);
        check("reload_abc_known", hash_v[0], to_port(ABC_DIGEST));
        check("reload_tag", 256'(tag_out_v[0]), 256'(32'h00000abc));
        release_result(0);

        // back-to-back stream of four random jobs, tags 0..3
        for (int k = 0; k < 4; k++) begin
            jv[k] = rand512()[255:0];
            jd[k] = rand512();
        end
        v_in = jv[0];
        data_in = jd[0];
        tag_in = 32'd0;
        out_ready_v[0] = 1'b1;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            lat = 0;
            if (k > 0) begin
                @(negedge clk);
                lat = 1;
            end
            while (out_valid_v[0] !== 1'b1 && lat < 300) begin
                @(negedge clk);
                lat++;
            end
            check("stream_interval", 256'(lat), (k == 0) ? 256'd16 : 256'd17);
            check("stream_hash", hash_v[0], model_hash(jv[k], jd[k]));
            check("stream_tag", 256'(tag_out_v[0]), 256'(k));
            if (k < 3) begin
                v_in = jv[k+1];
                data_in = jd[k+1];
                tag_in = 32'(k + 1);
            end else begin
                in_valid_v[0] = 1'b0;
            end
        end
        @(negedge clk);
        out_ready_v[0] = 1'b0;
        check("stream_end_valid", 256'(out_valid_v[0]), 256'(1'b0));
        check("stream_end_idle", 256'(busy_v[0]), 256'(1'b0));
        check("stream_end_hash_kept", hash_v[0], model_hash(jv[3], jd[3]));

        // random jobs with random consumer stalls
        for (int k = 0; k < 6; k++) begin
            v = rand512()[255:0];
            d = rand512();
            last_tag_a = $urandom();
            exp_a = model_hash(v, d);
            start_job(0, v, d, last_tag_a);
            wait_result(0, lat);
            check("rand_latency", 256'(lat), 256'd16);
            check("rand_hash", hash_v[0], exp_a);
            check("rand_tag", 256'(tag_out_v[0]), 256'(last_tag_a));
            hold = $urandom_range(0, 5);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                check("rand_hold_hash", hash_v[0], exp_a);
            end
            release_result(0);
        end

        // asynchronous reset in the middle of a slow job
        start_job(1, IV, empty_blk, 32'h55555555);
        repeat (29) @(negedge clk);
        check("mid_round_busy", 256'(busy_v[1]), 256'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 256'(out_valid_v[1]), 256'(1'b0));
        check("async_rst_hash", hash_v[1], 256'd0);
        check("async_rst_tag", 256'(tag_out_v[1]), 256'd0);
        check("async_rst_busy", 256'(busy_v[1]), 256'(1'b0));
        check("async_rst_hash_fast", hash_v[0], 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", 256'(in_ready_v[1]), 256'(1'b1));
        repeat (70) @(negedge clk);
        check("no_output_after_reset", 256'(out_valid_v[1]), 256'(1'b0));
        start_job(1, IV, abc_blk, 32'h12345678);
        wait_result(1, lat);
        check("post_reset_latency", 256'(lat), 256'd64);
        check("post_reset_abc", hash_v[1], to_port(ABC_DIGEST));
        check("post_reset_tag", 256'(tag_out_v[1]), 256'(32'h12345678));
        release_result(1);
        exp_b = to_port(ABC_DIGEST);

`ifdef SHA256_CORE_PIPE_ABORT_EN
        // abort at round 10 on the slow core
        start_job(1, IV, empty_blk, 32'h0000000a);
        repeat (9) @(negedge clk);
        abort_v[1] = 1'b1;
        #1;
        check("abort_ready_low", 256'(in_ready_v[1]), 256'(1'b0));
        @(negedge clk);
        abort_v[1] = 1'b0;
        check("abort_round_idle", 256'(busy_v[1]), 256'(1'b0));
        check("abort_round_ready", 256'(in_ready_v[1]), 256'(1'b1));
        repeat (70) @(negedge clk);
        check("abort_round_no_valid", 256'(out_valid_v[1]), 256'(1'b0));
        check("abort_round_hash_kept", hash_v[1], exp_b);

        // abort in IDLE blocks acceptance and is otherwise ignored
        v_in = IV;
        data_in = abc_blk;
        abort_v[0] = 1'b1;
        in_valid_v[0] = 1'b1;
        #1;
        check("abort_idle_ready_low", 256'(in_ready_v[0]), 256'(1'b0));
        @(negedge clk);
        abort_v[0] = 1'b0;
        in_valid_v[0] = 1'b0;
        check("abort_idle_not_accepted", 256'(busy_v[0]), 256'(1'b0));

        // abort in DONE wins over a handshake carrying a new job
        v = rand512()[255:0];
        d = rand512();
        last_tag_a = 32'hc0ffee00;
        exp_a = model_hash(v, d);
        start_job(0, v, d, last_tag_a);
        wait_result(0, lat);
        check("pre_abort_hash", hash_v[0], exp_a);
        abort_v[0] = 1'b1;
        out_ready_v[0] = 1'b1;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        out_ready_v[0] = 1'b0;
        in_valid_v[0] = 1'b0;
        check("abort_done_valid", 256'(out_valid_v[0]), 256'(1'b0));
        check("abort_done_no_reload", 256'(busy_v[0]), 256'(1'b0));
        check("abort_done_hash_kept", hash_v[0], exp_a);

        // abort on the last round edge
        start_job(0, rand512()[255:0], rand512(), 32'h0badf00d);
        repeat (15) @(negedge clk);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        check("abort_last_valid", 256'(out_valid_v[0]), 256'(1'b0));
        check("abort_last_idle", 256'(busy_v[0]), 256'(1'b0));
        check("abort_last_hash_kept", hash_v[0], exp_a);
        check("abort_last_tag_kept", 256'(tag_out_v[0]), 256'(last_tag_a));
        repeat (20) @(negedge clk);
        check("abort_last_no_late_valid", 256'(out_valid_v[0]), 256'(1'b0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
